// File: rtl/deint_pkg.sv
// Shared types and the 802.11a inverse-interleave index math for the deinterleaver.
// The DEINT_SOFT_EN macro sets the sample width in the files that use this package.
package deint_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int deint_s(input int n_bpsc);
    return (n_bpsc / 2 > 1) ? n_bpsc / 2 : 1;
  endfunction

  // Intermediates are 16 bits wide because 16*i reaches 4592 for N_CBPS=288.
  // Only the final k, which is always below N_CBPS, is returned in 11 bits.
  function automatic logic [10:0] deint_k(input logic [10:0] j, input int n_cbps,
                                          input int n_bpsc);
    logic [15:0] s, n, jj, i, t;
    s  = 16'(deint_s(n_bpsc));
    n  = 16'(n_cbps);
    jj = {5'd0, j};
    i  = s * (jj / s) + (jj + (16'd16 * jj) / n) % s;
    t  = 16'd16 * i - (n - 16'd1) * ((16'd16 * i) / n);
    return t[10:0];
  endfunction

endpackage

// File: rtl/deinterleaver_if.sv
// Two-lane valid/ready sample stream used on both sides of the deinterleaver.
// last is only meaningful on the output side.
interface deinterleaver_if #(
  parameter int W = 1
);
  logic [2*W-1:0] data;
  logic           valid;
  logic           ready;
  logic           last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/deint_addr_gen.sv
// Write-path address generator: maps the received pair (j, j+1) to
// deinterleaved buffer positions (k0, k1) combinationally.
module deint_addr_gen
  import deint_pkg::*;
#(
  parameter int N_CBPS = 48,
  parameter int N_BPSC = 1
) (
  input  logic [$clog2(N_CBPS)-1:0] j,
  output logic [$clog2(N_CBPS)-1:0] k0,
  output logic [$clog2(N_CBPS)-1:0] k1
);
  localparam int AW = $clog2(N_CBPS);

  assign k0 = AW'(deint_k(11'(j), N_CBPS, N_BPSC));
  assign k1 = AW'(deint_k(11'(j) + 11'd1, N_CBPS, N_BPSC));

endmodule

// File: rtl/deinterleaver.sv
// 802.11a receive deinterleaver: ping-pong symbol banks, two samples per beat each side.
// Define DEINT_SOFT_EN to carry SOFT_W-bit soft metrics instead of hard bits.
module deinterleaver
  import deint_pkg::*;
#(
  parameter int N_CBPS = 48,
  parameter int N_BPSC = 1
`ifdef DEINT_SOFT_EN
  , parameter int SOFT_W = 3
`endif
) (
  input  logic           clk,
  input  logic           rst,
  deinterleaver_if.slave  in_bus,
  deinterleaver_if.master out_bus
);
`ifdef DEINT_SOFT_EN
  localparam int W = SOFT_W;
`else
  localparam int W = 1;
`endif
  localparam int AW = $clog2(N_CBPS);
  localparam int BW = $clog2(N_CBPS / 2);
  localparam logic [AW-1:0] J_LAST = AW'(N_CBPS - 2);
  localparam logic [BW-1:0] B_LAST = BW'(N_CBPS / 2 - 1);

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [AW-1:0] wj_q, wj_d;
  logic [BW-1:0] rb_q, rb_d;

  logic [W-1:0]  mem [2][N_CBPS];
  logic [AW-1:0] k0, k1, rd0, rd1;
  logic          in_ok, out_ok, wr_fire, rd_fire;

  deint_addr_gen #(
    .N_CBPS (N_CBPS),
    .N_BPSC (N_BPSC)
  ) u_addr_gen (
    .j  (wj_q),
    .k0 (k0),
    .k1 (k1)
  );

  assign in_ok   = (bank_q[wbank_q] == EMPTY) || (bank_q[wbank_q] == FILLING);
  assign out_ok  = (bank_q[rbank_q] == FULL)  || (bank_q[rbank_q] == DRAINING);
  assign wr_fire = in_bus.valid && in_ok;
  assign rd_fire = out_ok && out_bus.ready;

  assign rd0 = AW'({rb_q, 1'b0});
  assign rd1 = AW'({rb_q, 1'b1});

  assign in_bus.ready  = in_ok;
  assign out_bus.valid = out_ok;
  assign out_bus.last  = out_ok && (rb_q == B_LAST);
  // Gate with valid so stale bank contents never leak out after reset.
  assign out_bus.data  = out_ok ? {mem[rbank_q][rd1], mem[rbank_q][rd0]} : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wbank_q   <= 1'b0;
      rbank_q   <= 1'b0;
      wj_q      <= '0;
      rb_q      <= '0;
    end else begin
      bank_q  <= bank_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wj_q    <= wj_d;
      rb_q    <= rb_d;
    end
  end

  // A bank being written is never the bank being read, so both updates can land together.
  always_comb begin
    bank_d  = bank_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    wj_d    = wj_q;
    rb_d    = rb_q;
    if (wr_fire) begin
      if (wj_q == J_LAST) begin
        bank_d[wbank_q] = FULL;
        wbank_d         = ~wbank_q;
        wj_d            = '0;
      end else begin
        bank_d[wbank_q] = FILLING;
        wj_d            = wj_q + AW'(2);
      end
    end
    if (rd_fire) begin
      if (rb_q == B_LAST) begin
        bank_d[rbank_q] = EMPTY;
        rbank_d         = ~rbank_q;
        rb_d            = '0;
      end else begin
        bank_d[rbank_q] = DRAINING;
        rb_d            = rb_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wbank_q][k0] <= in_bus.data[W-1:0];
      mem[wbank_q][k1] <= in_bus.data[2*W-1:W];
    end
  end

endmodule

// File: tb/tb_deinterleaver.sv
// Scoreboard bench for deinterleaver: a 48/1 instance exercised in depth and a 192/4 instance.
// Expected output comes from the forward 802.11a interleaver applied to each stimulus symbol.
module tb_deinterleaver;
`ifdef DEINT_SOFT_EN
  localparam int W = 3;
`else
  localparam int W = 1;
`endif
  localparam int NA = 48;
  localparam int BA = 1;
  localparam int NB = 192;
  localparam int BB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  deinterleaver_if #(.W(W)) in_a ();
  deinterleaver_if #(.W(W)) out_a ();
  deinterleaver_if #(.W(W)) in_b ();
  deinterleaver_if #(.W(W)) out_b ();

  deinterleaver #(.N_CBPS(NA), .N_BPSC(BA)
`ifdef DEINT_SOFT_EN
    , .SOFT_W(W)
`endif
  ) dut_a (.clk(clk), .rst(rst), .in_bus(in_a), .out_bus(out_a));

  deinterleaver #(.N_CBPS(NB), .N_BPSC(BB)
`ifdef DEINT_SOFT_EN
    , .SOFT_W(W)
`endif
  ) dut_b (.clk(clk), .rst(rst), .in_bus(in_b), .out_bus(out_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0]   sym [NB];
  logic [2*W:0]   q_a [$];
  logic [2*W:0]   q_b [$];
  logic [2*W-1:0] cap_a [NA/2];
  logic [2*W-1:0] cap_b [NB/2];
  logic [2*W:0]   e_a, e_b, prev_a;
  logic           stall_a = 1'b0;
  int beat_a = 0, beat_b = 0, first_a = 0, last_a = 0, last_acc_a = 0, in_stall_a = 0;
  bit rnd_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Forward interleaver: coded index k lands at received index j.
  function automatic int fwd_j(input int k, input int n, input int nbpsc);
    int s, i;
    s = (nbpsc / 2 > 1) ? nbpsc / 2 : 1;
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  task automatic push_exp(input int n, input int nbpsc, input bit to_b);
    logic [2*W:0] e;
    for (int b = 0; b < n / 2; b++) begin
      e = {(b == n / 2 - 1), sym[fwd_j(2 * b + 1, n, nbpsc)], sym[fwd_j(2 * b, n, nbpsc)]};
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
  endtask

  task automatic clear_sym();
    for (int i = 0; i < NB; i++) sym[i] = '0;
  endtask

  task automatic rand_sym();
    for (int i = 0; i < NB; i++) sym[i] = W'($urandom);
  endtask

  task automatic send_pair_a(input logic [2*W-1:0] d);
    int t;
    in_a.data  = d;
    in_a.valid = 1'b1;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (in_a.ready) break;
      if (t == 0) in_stall_a++;
    end
    if (t == 3000) tmo("in_accept_a");
    last_acc_a = cyc + 1;
    @(posedge clk);
    #1;
    in_a.valid = 1'b0;
  endtask

  task automatic send_sym_a(input int npairs, input bit push, input int gap_max);
    if (push) push_exp(NA, BA, 1'b0);
    for (int p = 0; p < npairs; p++) begin
      send_pair_a({sym[2 * p + 1], sym[2 * p]});
      if (gap_max > 0) repeat ($urandom % (gap_max + 1)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic send_pair_b(input logic [2*W-1:0] d);
    int t;
    in_b.data  = d;
    in_b.valid = 1'b1;
    for (t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (in_b.ready) break;
    end
    if (t == 3000) tmo("in_accept_b");
    @(posedge clk);
    #1;
    in_b.valid = 1'b0;
  endtask

  task automatic send_sym_b();
    push_exp(NB, BB, 1'b1);
    for (int p = 0; p < NB / 2; p++) send_pair_b({sym[2 * p + 1], sym[2 * p]});
  endtask

  task automatic drain(input bit is_b);
    int t;
    for (t = 0; t < 5000; t++) begin
      @(negedge clk);
      if ((is_b ? q_b.size() : q_a.size()) == 0) break;
    end
    if (t == 5000) tmo(is_b ? "drain_b" : "drain_a");
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_a"}, 64'(out_a.valid), 64'd0);
    check({tag, "_last_a"},  64'(out_a.last),  64'd0);
    check({tag, "_data_a"},  64'(out_a.data),  64'd0);
    check({tag, "_ready_a"}, 64'(in_a.ready),  64'd1);
    check({tag, "_valid_b"}, 64'(out_b.valid), 64'd0);
    check({tag, "_ready_b"}, 64'(in_b.ready),  64'd1);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    q_a.delete();
    q_b.delete();
    in_a.valid = 1'b0;
    in_b.valid = 1'b0;
    #10;
    rst = 1'b0;
    out_a.ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall_a = 1'b0;
    end else begin
      if (stall_a) begin
        check("hold_valid_a", 64'(out_a.valid), 64'd1);
        check("hold_beat_a", 64'({out_a.last, out_a.data}), 64'(prev_a));
      end
      if (out_a.valid && out_a.ready) begin
        if (q_a.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_beat_a: got %0h, expected no beat", out_a.data);
        end else begin
          e_a = q_a.pop_front();
          check("data_a", 64'(out_a.data), 64'(e_a[2*W-1:0]));
          check("last_a", 64'(out_a.last), 64'(e_a[2*W]));
        end
        cap_a[beat_a % (NA / 2)] = out_a.data;
        if (beat_a == 0) first_a = cyc + 1;
        last_a = cyc + 1;
        beat_a++;
      end
      stall_a = out_a.valid && !out_a.ready;
      prev_a  = {out_a.last, out_a.data};
    end
  end

  always @(negedge clk) begin
    if (!rst && out_b.valid && out_b.ready) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat_b: got %0h, expected no beat", out_b.data);
      end else begin
        e_b = q_b.pop_front();
        check("data_b", 64'(out_b.data), 64'(e_b[2*W-1:0]));
        check("last_b", 64'(out_b.last), 64'(e_b[2*W]));
      end
      cap_b[beat_b % (NB / 2)] = out_b.data;
      beat_b++;
    end
  end

  initial begin
    int acc0, rel, t;
    in_a.valid = 1'b0; in_a.data = '0; in_a.last = 1'b0; out_a.ready = 1'b1;
    in_b.valid = 1'b0; in_b.data = '0; in_b.last = 1'b0; out_b.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single marker at j=3 lands on k=1: beat 0, lane 1; latency one cycle.
    clear_sym();
    sym[3] = W'(1);
    beat_a = 0;
    send_sym_a(NA / 2, 1'b1, 0);
    acc0 = last_acc_a;
    drain(1'b0);
    check("j3_beat0", 64'(cap_a[0]), 64'({W'(1), W'(0)}));
    check("latency", 64'(first_a), 64'(acc0 + 1));

    clear_sym();
    sym[1] = W'(1);
    beat_a = 0;
    send_sym_a(NA / 2, 1'b1, 0);
    drain(1'b0);
    check("j1_beat8", 64'(cap_a[8]), 64'({W'(0), W'(1)}));

    // Four back-to-back symbols with the sink always ready.
    in_stall_a = 0;
    beat_a = 0;
    for (int s = 0; s < 4; s++) begin
      rand_sym();
      send_sym_a(NA / 2, 1'b1, 0);
      if (s == 0) acc0 = last_acc_a;
    end
    drain(1'b0);
    check("b2b_in_stalls", 64'(in_stall_a), 64'd0);
    check("b2b_first_out", 64'(first_a), 64'(acc0 + 1));
    check("b2b_out_span", 64'(last_a - first_a + 1), 64'(4 * NA / 2));

    // Sink stalled for two symbols, then released.
    out_a.ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rand_sym();
      send_sym_a(NA / 2, 1'b1, 0);
    end
    check("both_full_ready", 64'(in_a.ready), 64'd0);
    rel = cyc;
    out_a.ready = 1'b1;
    for (t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_a.ready) break;
    end
    if (t == 200) tmo("ready_rise");
    else check("ready_rise_cycles", 64'(cyc - rel), 64'(NA / 2));
    @(posedge clk);
    #1;
    drain(1'b0);

    // Random input gaps against a randomly stalling sink.
    rnd_en = 1'b1;
    fork
      begin
        for (int s = 0; s < 6; s++) begin
          rand_sym();
          send_sym_a(NA / 2, 1'b1, 2);
        end
        rnd_en = 1'b0;
      end
      begin
        while (rnd_en) begin
          @(posedge clk);
          #1;
          out_a.ready = ($urandom % 4) != 0;
        end
      end
    join
    out_a.ready = 1'b1;
    drain(1'b0);

    // Reset with one full bank waiting and the other stopped at j=20.
    out_a.ready = 1'b0;
    rand_sym();
    send_sym_a(NA / 2, 1'b1, 0);
    send_sym_a(10, 1'b0, 0);
    do_reset("mid_symbol");
    clear_sym();
    sym[3] = W'(1);
    beat_a = 0;
    send_sym_a(NA / 2, 1'b1, 0);
    drain(1'b0);
    check("after_rst_beat0", 64'(cap_a[0]), 64'({W'(1), W'(0)}));

    // Reset part-way through draining a symbol.
    out_a.ready = 1'b0;
    rand_sym();
    send_sym_a(NA / 2, 1'b1, 0);
    out_a.ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    do_reset("mid_drain");
    rand_sym();
    send_sym_a(NA / 2, 1'b1, 0);
    drain(1'b0);

    // 192/4 instance: j=1 -> k=16, j=12 -> k=17, both in beat 8.
    clear_sym();
    sym[1]  = W'(1);
    sym[12] = W'(1);
    beat_b = 0;
    send_sym_b();
    drain(1'b1);
    check("b_beat8", 64'(cap_b[8]), 64'({W'(1), W'(1)}));
    check("b_beat0", 64'(cap_b[0]), 64'd0);
    for (int s = 0; s < 2; s++) begin
      rand_sym();
      send_sym_b();
    end
    drain(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
